fe_mdc_commutator: RTL



---
 rtl/fe_mdc_commutator_if.sv | 24 ++
 rtl/fe_mdc_commutator.sv | 69 ++++++
 2 files changed

// File: rtl/fe_mdc_commutator_if.sv
// Two-lane complex stream bundle (lane 0 upper, lane 1 lower; [lane][I=0/Q=1]) for the MDC commutator.
// The master drives i_* and observes o_*; the commutator attaches as slave.
interface fe_mdc_commutator_if #(
  parameter int NBW_DATA = 8
);
  logic                                    i_valid;
  logic signed [1:0][1:0][NBW_DATA-1:0]    i_data;
  logic                                    o_valid;
  logic signed [1:0][1:0][NBW_DATA-1:0]    o_data;

  modport master (
    output i_valid,
    output i_data,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_data,
    output o_valid,
    output o_data
  );
endinterface

// File: rtl/fe_mdc_commutator.sv
// MDC delay-commutator: pairs samples DELAY apart for the next radix-2^2 butterfly; output m appears 1 clk after input m+DELAY.
// No backpressure: all state stalls in place while i_valid is low, o_valid drops and o_data holds.
module fe_mdc_commutator #(
  parameter int NBW_DATA = 8,
  parameter int DELAY    = 4,
  parameter int NBW_C    = $clog2(2*DELAY)
) (
  input  logic              clk,
  input  logic              rst_sync,
  fe_mdc_commutator_if.slave bus
);
  localparam int SEL_BIT = $clog2(DELAY);
  localparam int NBW_F   = $clog2(DELAY+1);

  typedef logic [1:0][NBW_DATA-1:0] lane_t;

  logic [NBW_C-1:0] cnt;
  logic [NBW_F-1:0] fill;
  lane_t            lo_dl [DELAY];
  lane_t            up_dl [DELAY];
  lane_t            u_lane;
  lane_t            b_lane;
  lane_t            p_lane;
  lane_t            q_lane;
  logic             sel;
  logic             primed;

  assign u_lane = bus.i_data[0];
  assign b_lane = lo_dl[DELAY-1];
  assign sel    = cnt[SEL_BIT];
  assign primed = (fill == NBW_F'(DELAY));

  // First half of each 2*DELAY block passes the upper lane straight on; second half swaps.
  always_comb begin
    p_lane = u_lane;
    q_lane = b_lane;
    if (sel) begin
      p_lane = b_lane;
      q_lane = u_lane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt         <= '0;
      fill        <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      for (int k = 0; k < DELAY; k++) begin
        lo_dl[k] <= '0;
        up_dl[k] <= '0;
      end
    end else begin
      bus.o_valid <= bus.i_valid && primed;
      if (bus.i_valid) begin
        // 2*DELAY is a power of two, so natural overflow gives the block wrap.
        cnt      <= cnt + NBW_C'(1);
        if (!primed) fill <= fill + NBW_F'(1);
        lo_dl[0] <= bus.i_data[1];
        up_dl[0] <= p_lane;
        for (int k = 1; k < DELAY; k++) begin
          lo_dl[k] <= lo_dl[k-1];
          up_dl[k] <= up_dl[k-1];
        end
        bus.o_data <= {q_lane, up_dl[DELAY-1]};
      end
    end
  end
endmodule
